camera_step_scheduler: RTL and testbench
========================================

CAMERA_STEP_SCHEDULER -- requirements
Module: camera_step_scheduler

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 20: served frames from the first step to the first auto-repeat step; legal range 1..63.
REQ-002 SHALL have parameter REPEAT_FRAMES, default 4: served frames between auto-repeat steps; legal range 1..63.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is in this domain.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port btn, input, 6: held-button levels, synchronous to clk; bit order [0]left [1]right [2]up [3]down [4]rot_left [5]rot_right.
REQ-006 SHALL have port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 SHALL have port x_inc / x_dec, output, 1 each: one-cycle step pulses to the x-offset incrementer.
REQ-008 SHALL have port y_inc / y_dec, output, 1 each: one-cycle step pulses to the y-offset incrementer.
REQ-009 SHALL have port a_inc / a_dec, output, 1 each: one-cycle step pulses to the angle incrementer.
REQ-010 SHALL have port busy, output, 1: high while a service sweep runs.
REQ-011 SHALL have port overrun, output, 1: sticky flag meaning a frame_tick was dropped.

Function
REQ-012 SHALL map each axis's inc/dec buttons as x: right/left, y: down/up, a: rot_left/rot_right.
REQ-013 SHALL use a top FSM with states IDLE, SERVE_X, SERVE_Y, SERVE_A.
REQ-014 SHALL, when frame_tick is seen in IDLE at cycle T, be in SERVE_X at T+1, SERVE_Y at T+2, SERVE_A at T+3, then return to IDLE at T+4.
REQ-015 SHALL assert busy exactly in the SERVE_* states.
REQ-016 SHALL evaluate each axis only in its own SERVE slot, sampling btn in that same cycle.
REQ-017 SHALL drive step outputs combinationally from the slot evaluation, so at most one step pulse is high in any cycle.
REQ-018 SHALL have each axis compute dir = inc XOR dec; with neither or both buttons held, the axis goes to A_IDLE with count 0 and emits no pulse.
REQ-019 SHALL run a per-axis FSM with states A_IDLE, A_HOLD, A_REPEAT and a 6-bit count.
REQ-020 SHALL, when dir is valid and the axis is in A_IDLE or dir differs from the stored direction: emit a pulse, store dir, go to A_HOLD, and load count = HOLD_FRAMES-1.
REQ-021 SHALL, in A_HOLD or A_REPEAT with the same dir: if count = 0, emit a pulse, go to A_REPEAT and load count = REPEAT_FRAMES-1; otherwise decrement count with no pulse.
REQ-022 SHALL, on a frame_tick arriving while busy, set a one-deep pending bit; a sweep then starts on the cycle after SERVE_A, with no IDLE cycle in between.
REQ-023 SHALL, on a frame_tick arriving while pending is already set, drop the tick and set overrun.
REQ-024 SHALL clear overrun only by reset.
REQ-025 SHALL treat a frame_tick in the same cycle as the SERVE_A to IDLE transition as pending, never as lost.

Reset
REQ-026 SHALL, while reset_n is low, force the top FSM to IDLE, every axis to A_IDLE, all counts to 0, and pending, overrun, busy and all step outputs to 0, asynchronously.
REQ-027 SHALL abandon a sweep interrupted by reset; after release no pulse is emitted until the next frame_tick.
REQ-028 SHALL deassert reset in a way that is safe for the registered state, with the first frame_tick accepted at the second clk edge after reset_n rises.

Structure
REQ-029 SHALL place the top-state and axis-state encodings, the btn bit indices, and the HOLD/REPEAT default constants in the shared package camera_pkg.
REQ-030 SHALL implement per-axis logic as sub-module axis_repeat, instantiated three times; the top holds only the sweep FSM, pending and overrun.
REQ-031 SHALL stay within 120-400 RTL lines in total.

Verification (HOLD_FRAMES=3, REPEAT_FRAMES=2)
REQ-032 SHALL verify a single tap: btn[1] held for one frame, tick at T -> x_inc high only at T+1, busy high T+1..T+3, nothing on later frames.
REQ-033 SHALL verify auto-repeat: btn[3] held across ticks 0..8 -> y_inc on ticks 0, 3, 5, 7 at slot cycle tick+2, none on the other ticks.
REQ-034 SHALL verify opposing buttons: btn[4] and btn[5] held together -> no a_inc/a_dec; releasing btn[5] on the next tick -> a_inc immediately, and the hold count restarts.
REQ-035 SHALL verify tick overrun: ticks at T and T+1 -> second sweep T+4..T+6, overrun=0; ticks at T, T+1, T+2 -> overrun=1 and only two sweeps.
REQ-036 SHALL verify direction reversal: left held through 2 ticks, then right -> x_inc on the reversal tick, and the hold period restarts.
REQ-037 SHALL verify reset mid-sweep: reset_n low at T+2 -> no y/a pulse, all outputs 0, and the axis counts restart at the first tick after release.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared encodings and defaults for the camera step scheduler.
// Covers the sweep states, the axis states, the button bit positions and the debug view.
package camera_pkg;

  localparam int HOLD_FRAMES_DEFAULT   = 20;
  localparam int REPEAT_FRAMES_DEFAULT = 4;
  localparam int COUNT_W               = 6;

  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_UP        = 2;
  localparam int BTN_DOWN      = 3;
  localparam int BTN_ROT_LEFT  = 4;
  localparam int BTN_ROT_RIGHT = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_X = 2'd1,
    SERVE_Y = 2'd2,
    SERVE_A = 2'd3
  } top_state_t;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_HOLD   = 2'd1,
    A_REPEAT = 2'd2
  } axis_state_t;

  typedef struct packed {
    top_state_t  top;
    axis_state_t x;
    axis_state_t y;
    axis_state_t a;
  } debug_t;

endpackage

// File: rtl/axis_repeat.sv
// Per-axis hold/auto-repeat engine. It is evaluated only while its sweep slot is active.
// Step pulses are combinational from that evaluation.
module axis_repeat
  import camera_pkg::*;
#(
  parameter int HOLD_FRAMES   = HOLD_FRAMES_DEFAULT,
  parameter int REPEAT_FRAMES = REPEAT_FRAMES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slot,
  input  logic        inc,
  input  logic        dec,
  output logic        step_inc,
  output logic        step_dec,
  output axis_state_t state
);

  localparam logic [COUNT_W-1:0] HOLD_LOAD   = COUNT_W'(HOLD_FRAMES - 1);
  localparam logic [COUNT_W-1:0] REPEAT_LOAD = COUNT_W'(REPEAT_FRAMES - 1);

  axis_state_t        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic               valid;
  logic               fresh;
  logic               pulse;

  // dir is 1 for inc and 0 for dec. It is meaningful only when exactly one button is held.
  assign valid = inc ^ dec;
  assign fresh = (state_q == A_IDLE) || (inc != dir_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    if (slot) begin
      if (!valid) begin
        state_d = A_IDLE;
        count_d = '0;
      end else if (fresh) begin
        state_d = A_HOLD;
        count_d = HOLD_LOAD;
        dir_d   = inc;
      end else if (count_q == '0) begin
        state_d = A_REPEAT;
        count_d = REPEAT_LOAD;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_comb begin
    pulse    = slot && valid && (fresh || (count_q == '0));
    step_inc = pulse & inc;
    step_dec = pulse & dec;
    state    = state_q;
  end

endmodule

// File: rtl/camera_step_scheduler.sv
// Frame-paced step scheduler: each frame_tick starts one sweep that services x, y and angle in turn.
// A single queued tick covers a tick that arrives mid-sweep; further ticks raise a sticky overrun.
module camera_step_scheduler
  import camera_pkg::*;
#(
  parameter int HOLD_FRAMES   = HOLD_FRAMES_DEFAULT,
  parameter int REPEAT_FRAMES = REPEAT_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] btn,
  input  logic       frame_tick,
  output logic       x_inc,
  output logic       x_dec,
  output logic       y_inc,
  output logic       y_dec,
  output logic       a_inc,
  output logic       a_dec,
  output logic       busy,
  output logic       overrun,
  output debug_t     debug
);

  top_state_t  state_q, state_d;
  logic        rst_n_sync;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        slot_x, slot_y, slot_a;
  axis_state_t x_state, y_state, a_state;

  // Reset asserts asynchronously and is released one edge later. The second edge after release is live.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_n_sync <= 1'b0;
    else          rst_n_sync <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // A tick in SERVE_A, or a queued one, chains straight into the next sweep.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE:    if (frame_tick) state_d = SERVE_X;
      SERVE_X: state_d = SERVE_Y;
      SERVE_Y: state_d = SERVE_A;
      SERVE_A: state_d = (pending_q || frame_tick) ? SERVE_X : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == SERVE_A) begin
      pending_d = pending_q & frame_tick;
    end else if (state_q != IDLE && frame_tick) begin
      pending_d = 1'b1;
      if (pending_q) overrun_d = 1'b1;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    slot_x    = (state_q == SERVE_X);
    slot_y    = (state_q == SERVE_Y);
    slot_a    = (state_q == SERVE_A);
    overrun   = overrun_q;
    debug.top = state_q;
    debug.x   = x_state;
    debug.y   = y_state;
    debug.a   = a_state;
  end

  axis_repeat #(.HOLD_FRAMES(HOLD_FRAMES), .REPEAT_FRAMES(REPEAT_FRAMES)) u_axis_x (
    .clk      (clk),
    .rst_n    (rst_n_sync),
    .slot     (slot_x),
    .inc      (btn[BTN_RIGHT]),
    .dec      (btn[BTN_LEFT]),
    .step_inc (x_inc),
    .step_dec (x_dec),
    .state    (x_state)
  );

  axis_repeat #(.HOLD_FRAMES(HOLD_FRAMES), .REPEAT_FRAMES(REPEAT_FRAMES)) u_axis_y (
    .clk      (clk),
    .rst_n    (rst_n_sync),
    .slot     (slot_y),
    .inc      (btn[BTN_DOWN]),
    .dec      (btn[BTN_UP]),
    .step_inc (y_inc),
    .step_dec (y_dec),
    .state    (y_state)
  );

  axis_repeat #(.HOLD_FRAMES(HOLD_FRAMES), .REPEAT_FRAMES(REPEAT_FRAMES)) u_axis_a (
    .clk      (clk),
    .rst_n    (rst_n_sync),
    .slot     (slot_a),
    .inc      (btn[BTN_ROT_LEFT]),
    .dec      (btn[BTN_ROT_RIGHT]),
    .step_inc (a_inc),
    .step_dec (a_dec),
    .state    (a_state)
  );

endmodule

// File: tb/tb_camera_step_scheduler.sv
// Directed bench for camera_step_scheduler with HOLD_FRAMES=3 and REPEAT_FRAMES=2.
// Observation byte layout: {overrun, busy, a_dec, a_inc, y_dec, y_inc, x_dec, x_inc}.
module tb_camera_step_scheduler;
  import camera_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] btn;
  logic       frame_tick;
  logic       x_inc, x_dec, y_inc, y_dec, a_inc, a_dec, busy, overrun;
  debug_t     debug;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  camera_step_scheduler #(.HOLD_FRAMES(3), .REPEAT_FRAMES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .frame_tick (frame_tick),
    .x_inc      (x_inc),
    .x_dec      (x_dec),
    .y_inc      (y_inc),
    .y_dec      (y_dec),
    .a_inc      (a_inc),
    .a_dec      (a_dec),
    .busy       (busy),
    .overrun    (overrun),
    .debug      (debug)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  function automatic logic [7:0] pack_obs();
    return {overrun, busy, a_dec, a_inc, y_dec, y_inc, x_dec, x_inc};
  endfunction

  // The expected five-cycle view of one sweep: tick cycle, three slots, then the return to idle.
  function automatic logic [4:0][7:0] frame_exp(input logic [7:0] s1, input logic [7:0] s2,
                                                 input logic [7:0] s3, input logic ov);
    logic [4:0][7:0] f;
    logic [7:0]      o8;
    o8   = {ov, 7'b0};
    f[0] = o8;
    f[1] = o8 | 8'h40 | s1;
    f[2] = o8 | 8'h40 | s2;
    f[3] = o8 | 8'h40 | s3;
    f[4] = o8;
    return f;
  endfunction

  // Inputs are applied just after posedge and outputs are sampled at negedge.
  task automatic drive_cycle(input logic tick, input logic [5:0] b, output logic [7:0] o);
    btn        = b;
    frame_tick = tick;
    @(negedge clk);
    o = pack_obs();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic run_frame(input logic [5:0] b, output logic [4:0][7:0] o);
    logic [7:0] t;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k == 0, b, t);
      o[k] = t;
    end
  endtask

  task automatic test_reset();
    logic [7:0] o;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 6'h3F, o);
      n_cmp++;
      if (o !== 8'h00 || debug !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: outputs %h debug %h, required 00 / 00", i, o, debug);
      end
    end
    reset_n = 1'b1;
    drive_cycle(1'b1, 6'h00, o);
    drive_cycle(1'b1, 6'h00, o);
    n_cmp++;
    if (o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_first_edge: outputs %h, required 00", o);
    end
    drive_cycle(1'b0, 6'h00, o);
    n_cmp++;
    if (o !== 8'h40) begin
      n_fail++;
      $display("FAIL reset_second_edge: outputs %h, required 40", o);
    end
    drive_cycle(1'b0, 6'h00, o);
    drive_cycle(1'b0, 6'h00, o);
    drive_cycle(1'b0, 6'h00, o);
    n_cmp++;
    if (o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_sweep_end: outputs %h, required 00", o);
    end
  endtask

  task automatic test_single_tap();
    logic [4:0][7:0] f, e;
    run_frame(6'h02, f);
    e = frame_exp(8'h01, 8'h00, 8'h00, 1'b0);
    n_cmp++;
    if (f !== e) begin
      n_fail++;
      $display("FAIL tap_frame: got %h required %h", f, e);
    end
    for (int i = 0; i < 2; i++) begin
      run_frame(6'h00, f);
      e = frame_exp(8'h00, 8'h00, 8'h00, 1'b0);
      n_cmp++;
      if (f !== e) begin
        n_fail++;
        $display("FAIL tap_after[%0d]: got %h required %h", i, f, e);
      end
    end
    n_cmp++;
    if (debug.x !== A_IDLE) begin
      n_fail++;
      $display("FAIL tap_axis_idle: x state %0d required %0d", debug.x, A_IDLE);
    end
  endtask

  task automatic test_auto_repeat();
    logic [4:0][7:0] f, e;
    logic [7:0]      s;
    for (int i = 0; i < 9; i++)
      exp_q.push_back((i == 0 || i == 3 || i == 5 || i == 7) ? 8'h04 : 8'h00);
    for (int i = 0; i < 9; i++) begin
      run_frame(6'h08, f);
      s = exp_q.pop_front();
      e = frame_exp(8'h00, s, 8'h00, 1'b0);
      n_cmp++;
      if (f !== e) begin
        n_fail++;
        $display("FAIL repeat_tick[%0d]: got %h required %h", i, f, e);
      end
    end
    run_frame(6'h00, f);
  endtask

  task automatic test_opposing();
    logic [4:0][7:0] f, e;
    logic [3:0]      pat;
    run_frame(6'h30, f);
    e = frame_exp(8'h00, 8'h00, 8'h00, 1'b0);
    n_cmp++;
    if (f !== e) begin
      n_fail++;
      $display("FAIL opposing_both: got %h required %h", f, e);
    end
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      run_frame(6'h10, f);
      e = frame_exp(8'h00, 8'h00, pat[i] ? 8'h10 : 8'h00, 1'b0);
      n_cmp++;
      if (f !== e) begin
        n_fail++;
        $display("FAIL opposing_release[%0d]: got %h required %h", i, f, e);
      end
    end
    run_frame(6'h00, f);
  endtask

  task automatic test_direction_reversal();
    logic [4:0][7:0] f, e;
    logic [5:0]      b;
    logic [7:0]      s;
    for (int i = 0; i < 6; i++) begin
      b = (i < 2) ? 6'h01 : 6'h02;
      case (i)
        0:       s = 8'h02;
        2, 5:    s = 8'h01;
        default: s = 8'h00;
      endcase
      run_frame(b, f);
      e = frame_exp(s, 8'h00, 8'h00, 1'b0);
      n_cmp++;
      if (f !== e) begin
        n_fail++;
        $display("FAIL reversal[%0d]: got %h required %h", i, f, e);
      end
    end
    run_frame(6'h00, f);
  endtask

  task automatic test_overrun();
    logic [7:0][7:0] got, e;
    logic [7:0]      mask, t;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          mask = 8'b0000_0011;
          e    = {8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
        end
        1: begin
          mask = 8'b0000_1001;
          e    = {8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
        end
        default: begin
          mask = 8'b0000_0111;
          e    = {8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40, 8'h00};
        end
      endcase
      for (int k = 0; k < 8; k++) begin
        drive_cycle(mask[k], 6'h00, t);
        got[k] = t;
      end
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL overrun_case[%0d]: got %h required %h", c, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [4:0][7:0] f, e;
    logic [7:0]      o;
    run_frame(6'h02, f);
    e = frame_exp(8'h01, 8'h00, 8'h00, 1'b1);
    n_cmp++;
    if (f !== e) begin
      n_fail++;
      $display("FAIL mid_prime: got %h required %h", f, e);
    end
    drive_cycle(1'b1, 6'h0A, o);
    drive_cycle(1'b0, 6'h0A, o);
    n_cmp++;
    if (o !== 8'hC0) begin
      n_fail++;
      $display("FAIL mid_hold_slot: outputs %h, required c0", o);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 6'h0A, o);
      n_cmp++;
      if (o !== 8'h00 || debug !== '0) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: outputs %h debug %h, required 00 / 00", i, o, debug);
      end
    end
    reset_n = 1'b1;
    drive_cycle(1'b0, 6'h0A, o);
    drive_cycle(1'b0, 6'h0A, o);
    n_cmp++;
    if (o !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_quiet_after_release: outputs %h, required 00", o);
    end
    run_frame(6'h0A, f);
    e = frame_exp(8'h01, 8'h04, 8'h00, 1'b0);
    n_cmp++;
    if (f !== e) begin
      n_fail++;
      $display("FAIL mid_restart: got %h required %h", f, e);
    end
    run_frame(6'h0A, f);
    e = frame_exp(8'h00, 8'h00, 8'h00, 1'b0);
    n_cmp++;
    if (f !== e) begin
      n_fail++;
      $display("FAIL mid_count_restart: got %h required %h", f, e);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    btn        = 6'h00;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_tap();
    test_auto_repeat();
    test_opposing();
    test_direction_reversal();
    test_overrun();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
